fifo_burst_reader: RTL and testbench

//  Drain side of sync_fifo: accepts a burst request of N words from the DSA, pops exactly N words

---
 rtl/fifo_burst_reader.sv | 184 ++++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
//
// Drain side of a sync_fifo. Accepts a burst request of req_len words, pops
// exactly that many words from the FIFO read port and presents them as a
// valid/ready stream, flagging the final word with out_last. A 2-entry output
// buffer hides the FIFO's 1-cycle read latency. Reads are only issued when
// the buffer can hold the word, so the stream runs at 1 word/cycle.
//
// Ports
//   clk, rst_n      clock (posedge) and asynchronous active-low reset
//   req_valid/ready burst request handshake; req_len sampled on acceptance
//   fifo_read_en    pops one FIFO word; never asserted while fifo_empty=1
//   fifo_read_data  FIFO word, valid the cycle after fifo_read_en
//   fifo_empty      FIFO empty flag
//   out_valid/ready output stream handshake; out_data, out_last with it
//   busy            high while a burst is being read or drained
//   words_left      words of the current burst not yet popped on the output
//   done            one-cycle pulse after a burst completes
// -----------------------------------------------------------------------------
module fifo_burst_reader #(
   parameter int FIFO_PTR   = 10,
   parameter int FIFO_WIDTH = 32,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [LEN_WIDTH-1:0]  req_len,
   output logic                  fifo_read_en,
   input  logic [FIFO_WIDTH-1:0] fifo_read_data,
   input  logic                  fifo_empty,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [FIFO_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic [LEN_WIDTH-1:0]  words_left,
   output logic                  done
);

   // The attached FIFO must have at least one address bit.
   if (FIFO_PTR < 1) begin : g_bad_fifo_ptr
      $error("fifo_burst_reader: FIFO_PTR must be at least 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BURST,
      ST_DRAIN
   } state_t;

   state_t                state_q, state_d;
   logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
   logic [LEN_WIDTH-1:0]  words_left_q, words_left_d;
   logic                  inflight_q, inflight_d;
   logic [1:0]            occ_q, occ_d;
   logic                  head_q, head_d;
   logic [FIFO_WIDTH-1:0] buf_mem_q [2];
   logic [FIFO_WIDTH-1:0] buf_mem_d [2];
   logic                  done_q, done_d;

   logic                  accept;
   logic                  pop;
   logic                  read_en;
   logic                  wr_slot;
   logic [2:0]            pending;

   // Handshakes and the credit-based read issue. pending is the buffer
   // occupancy once this cycle's capture and pop have both taken effect; a
   // new read is only allowed if its word will still fit next cycle. The
   // combinational path from out_ready to fifo_read_en is deliberate: it lets
   // a pop free a slot for a read in the same cycle.
   assign accept  = req_valid & (state_q == ST_IDLE);
   assign pop     = (occ_q != 2'd0) & out_ready;
   assign pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign read_en = (state_q == ST_BURST) & ~fifo_empty &
                    (issue_cnt_q != '0) & (pending < 3'd2);

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path
      // leaves one unassigned and no latch is inferred.
      state_d      = state_q;
      issue_cnt_d  = issue_cnt_q;
      words_left_d = words_left_q;
      inflight_d   = read_en;
      occ_d        = pending[1:0];
      head_d       = head_q ^ pop;
      buf_mem_d    = buf_mem_q;
      done_d       = 1'b0;
      wr_slot      = head_q ^ occ_q[0];

      // A read issued last cycle lands in the slot just behind the current
      // contents. With occ=1 and a pop this is exactly the slot that becomes
      // the new head.
      if (inflight_q) begin
         buf_mem_d[wr_slot] = fifo_read_data;
      end

      if (read_en) begin
         issue_cnt_d = issue_cnt_q - LEN_WIDTH'(1);
      end

      if (pop && (words_left_q != '0)) begin
         words_left_d = words_left_q - LEN_WIDTH'(1);
      end

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (req_len != '0) begin
                  state_d      = ST_BURST;
                  issue_cnt_d  = req_len;
                  words_left_d = req_len;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_BURST: begin
            if (read_en && (issue_cnt_q == LEN_WIDTH'(1))) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (pop && (words_left_q == LEN_WIDTH'(1))) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values from before the clock edge, independent of process order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         issue_cnt_q  <= '0;
         words_left_q <= '0;
         inflight_q   <= 1'b0;
         occ_q        <= 2'd0;
         head_q       <= 1'b0;
         done_q       <= 1'b0;
         // NOTE: the two buffer entries are reset as well, because out_data
         // shows the head entry and must read 0 out of reset.
         buf_mem_q[0] <= '0;
         buf_mem_q[1] <= '0;
      end else begin
         state_q      <= state_d;
         issue_cnt_q  <= issue_cnt_d;
         words_left_q <= words_left_d;
         inflight_q   <= inflight_d;
         occ_q        <= occ_d;
         head_q       <= head_d;
         done_q       <= done_d;
         buf_mem_q[0] <= buf_mem_d[0];
         buf_mem_q[1] <= buf_mem_d[1];
      end
   end

   // The read credit rule keeps occupancy at 2 or below; a third word would
   // mean the issue logic is broken.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (pending != 3'd3)
            else $error("fifo_burst_reader: output buffer overflow");
      end
   end

   assign req_ready    = (state_q == ST_IDLE);
   assign busy         = (state_q != ST_IDLE);
   assign fifo_read_en = read_en;
   assign out_valid    = (occ_q != 2'd0);
   assign out_data     = buf_mem_q[head_q];
   assign out_last     = (occ_q != 2'd0) & (words_left_q == LEN_WIDTH'(1));
   assign words_left   = words_left_q;
   assign done         = done_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_burst_reader
//
// Directed bench for fifo_burst_reader. A small behavioural sync_fifo model
// (registered read data, shared reset) feeds the DUT. A monitor checks every
// output word against the order written into the FIFO, checks out_last against
// the accepted burst length, checks that reads never happen while empty or
// beyond the 2-word credit, and checks that a stalled word is held stable.
// -----------------------------------------------------------------------------
module tb_fifo_burst_reader;

   localparam int FW = 32;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [LW-1:0] req_len = '0;
   logic          fifo_read_en;
   logic [FW-1:0] fifo_read_data;
   logic          fifo_empty;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [FW-1:0] out_data;
   logic          out_last;
   logic          busy;
   logic [LW-1:0] words_left;
   logic          done;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fifo_burst_reader #(
      .FIFO_PTR  (10),
      .FIFO_WIDTH(FW),
      .LEN_WIDTH (LW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_len       (req_len),
      .fifo_read_en  (fifo_read_en),
      .fifo_read_data(fifo_read_data),
      .fifo_empty    (fifo_empty),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_last      (out_last),
      .busy          (busy),
      .words_left    (words_left),
      .done          (done)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv)
         else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
         end
   endtask

   // ---------------- sync_fifo model ----------------
   logic [FW-1:0] fmem [0:255];
   int            wr_ptr;
   int            rd_ptr;
   logic          wr_en = 1'b0;
   logic [FW-1:0] wr_data = '0;
   logic [FW-1:0] exp_q [$];

   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr         <= 0;
         rd_ptr         <= 0;
         fifo_read_data <= '0;
         exp_q.delete();
      end else begin
         if (wr_en) begin
            fmem[wr_ptr[7:0]] <= wr_data;
            wr_ptr            <= wr_ptr + 1;
            exp_q.push_back(wr_data);
         end
         if (fifo_read_en) begin
            fifo_read_data <= fmem[rd_ptr[7:0]];
            rd_ptr         <= rd_ptr + 1;
         end
      end
   end

   // ---------------- output / protocol monitor ----------------
   int            rd_cnt = 0;
   int            pop_cnt = 0;
   int            last_cnt = 0;
   int            exp_left = 0;
   logic          mon_pop;
   logic          hold_v = 1'b0;
   logic [FW-1:0] hold_data;
   logic          hold_last;

   always @(negedge clk) begin
      if (!rst_n) begin
         rd_cnt   = 0;
         pop_cnt  = 0;
         last_cnt = 0;
         exp_left = 0;
         hold_v   = 1'b0;
      end else begin
         mon_pop = out_valid & out_ready;
         if (req_valid && req_ready) exp_left = int'(req_len);
         if (hold_v) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, hold_data);
            check("hold_last", out_last, hold_last);
         end
         if (fifo_read_en) begin
            check("read_while_empty", fifo_empty, 0);
            check("read_credit", (rd_cnt - pop_cnt + 1 - int'(mon_pop)) <= 2, 1);
            rd_cnt++;
         end
         if (mon_pop) begin
            check("exp_word_available", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("out_data", out_data, exp_q.pop_front());
            check("out_last", out_last, exp_left == 1);
            if (exp_left != 0) exp_left--;
            pop_cnt++;
            if (out_last) last_cnt++;
         end
         hold_v    = out_valid & ~out_ready;
         hold_data = out_data;
         hold_last = out_last;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push(input int n, input logic [FW-1:0] base);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         wr_en   = 1'b1;
         wr_data = base + FW'(i);
      end
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   // Presents a request for one cycle; returns one step into the cycle after
   // acceptance.
   task automatic request(input int len);
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_len   = LW'(len);
      @(negedge clk);
      check("req_ready_at_accept", req_ready, 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_done(input int max_cycles, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < max_cycles && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      #1;
      check(tag, seen, 1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_req_ready"}, req_ready, 1);
      check({pfx, "_read_en"}, fifo_read_en, 0);
      check({pfx, "_out_valid"}, out_valid, 0);
      check({pfx, "_out_data"}, out_data, 0);
      check({pfx, "_out_last"}, out_last, 0);
      check({pfx, "_busy"}, busy, 0);
      check({pfx, "_words_left"}, words_left, 0);
      check({pfx, "_done"}, done, 0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int  p0;
      int  l0;
      bit  seen;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_values("rst");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // 1: len 4 from a FIFO holding 8, out_ready=1
      push(8, 32'h100);
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_len   = 16'd4;
      @(negedge clk);                                   // cycle T
      check("t1_T_req_ready", req_ready, 1);
      check("t1_T_read_en", fifo_read_en, 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);                                   // T+1
      check("t1_T1_read_en", fifo_read_en, 1);
      check("t1_T1_busy", busy, 1);
      check("t1_T1_req_ready", req_ready, 0);
      check("t1_T1_words_left", words_left, 4);
      check("t1_T1_out_valid", out_valid, 0);
      @(negedge clk);                                   // T+2
      check("t1_T2_read_en", fifo_read_en, 1);
      check("t1_T2_out_valid", out_valid, 0);
      @(negedge clk);                                   // T+3
      check("t1_T3_out_valid", out_valid, 1);
      check("t1_T3_out_data", out_data, 32'h100);
      check("t1_T3_out_last", out_last, 0);
      check("t1_T3_read_en", fifo_read_en, 1);
      @(negedge clk);                                   // T+4
      check("t1_T4_read_en", fifo_read_en, 1);
      check("t1_T4_words_left", words_left, 3);
      @(negedge clk);                                   // T+5
      check("t1_T5_read_en", fifo_read_en, 0);
      check("t1_T5_out_valid", out_valid, 1);
      check("t1_T5_words_left", words_left, 2);
      @(negedge clk);                                   // T+6
      check("t1_T6_out_valid", out_valid, 1);
      check("t1_T6_out_data", out_data, 32'h103);
      check("t1_T6_out_last", out_last, 1);
      @(negedge clk);                                   // T+7
      check("t1_T7_done", done, 1);
      check("t1_T7_out_valid", out_valid, 0);
      check("t1_T7_busy", busy, 0);
      check("t1_T7_words_left", words_left, 0);
      @(negedge clk);                                   // T+8
      check("t1_T8_done", done, 0);
      check("t1_fifo_count", wr_ptr - rd_ptr, 4);

      do_reset();

      // 2: len 6 from an empty FIFO; 2 words arrive at T+5, 4 more later
      p0 = pop_cnt;
      l0 = last_cnt;
      request(6);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("t2_no_read_empty", fifo_read_en, 0);
      end
      push(2, 32'h200);
      repeat (10) @(negedge clk);
      #1;
      check("t2_mid_pops", pop_cnt - p0, 2);
      check("t2_mid_words_left", words_left, 4);
      check("t2_mid_busy", busy, 1);
      check("t2_mid_read_en", fifo_read_en, 0);
      check("t2_mid_out_valid", out_valid, 0);
      push(4, 32'h210);
      wait_done(30, "t2_done");
      check("t2_pops", pop_cnt - p0, 6);
      check("t2_lasts", last_cnt - l0, 1);

      // 3: len 10 with out_ready cycling 1,0,0,1
      push(10, 32'h300);
      p0 = pop_cnt;
      l0 = last_cnt;
      request(10);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         out_ready = ((i % 4) == 0) || ((i % 4) == 3);
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      #1;
      check("t3_done", seen, 1);
      check("t3_pops", pop_cnt - p0, 10);
      check("t3_lasts", last_cnt - l0, 1);

      // 4: zero-length request
      @(posedge clk); #1;
      out_ready = 1'b1;
      req_valid = 1'b1;
      req_len   = 16'd0;
      @(negedge clk);
      check("t4_T_req_ready", req_ready, 1);
      check("t4_T_read_en", fifo_read_en, 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("t4_T1_done", done, 1);
      check("t4_T1_req_ready", req_ready, 1);
      check("t4_T1_busy", busy, 0);
      check("t4_T1_read_en", fifo_read_en, 0);
      @(negedge clk);
      check("t4_T2_done", done, 0);

      // 5: reset after 3 of 8 words, then a clean len 2 burst
      push(8, 32'h500);
      p0 = pop_cnt;
      request(8);
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk); #1;
         if (pop_cnt - p0 >= 3) seen = 1'b1;
      end
      check("t5_three_popped", seen, 1);
      check("t5_busy_before_reset", busy, 1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_reset_values("t5_async");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      push(2, 32'h600);
      p0 = pop_cnt;
      l0 = last_cnt;
      request(2);
      wait_done(20, "t5_done");
      check("t5_pops", pop_cnt - p0, 2);
      check("t5_lasts", last_cnt - l0, 1);

      // 6: back-to-back len 1 then len 3, second held until the first is done
      push(4, 32'h700);
      p0 = pop_cnt;
      l0 = last_cnt;
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_len   = 16'd1;
      @(negedge clk);                                   // T
      check("t6_T_req_ready", req_ready, 1);
      @(posedge clk); #1;
      req_len = 16'd3;
      @(negedge clk);                                   // T+1
      check("t6_T1_req_ready", req_ready, 0);
      check("t6_T1_busy", busy, 1);
      @(negedge clk);                                   // T+2
      check("t6_T2_req_ready", req_ready, 0);
      @(negedge clk);                                   // T+3
      check("t6_T3_out_valid", out_valid, 1);
      check("t6_T3_out_data", out_data, 32'h700);
      check("t6_T3_out_last", out_last, 1);
      check("t6_T3_req_ready", req_ready, 0);
      @(negedge clk);                                   // T+4
      check("t6_T4_done", done, 1);
      check("t6_T4_req_ready", req_ready, 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("t6_second_busy", busy, 1);
      check("t6_second_words_left", words_left, 3);
      wait_done(20, "t6_done");
      check("t6_pops", pop_cnt - p0, 4);
      check("t6_lasts", last_cnt - l0, 2);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
